tia_motion_decoder: RTL and testbench

//  Inverse of the TIA motion registers: observes the five extra-clock strobes
//  (p0/p1/m0/m1/bl ec_bar) during an HMOVE window and recovers the 4-bit HMxx

---
 rtl/tia_motion_decoder_pkg.sv | 19 +
 rtl/tia_motion_decoder_channel.sv | 21 ++
 rtl/tia_motion_decoder.sv | 90 +++++++++
 tb/tb_tia_motion_decoder.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/tia_motion_decoder_pkg.sv
// tia_motion_decoder_pkg: shared object indices, window sizing, FSM states and nibble decode
package tia_motion_decoder_pkg;
  localparam int P0 = 0;
  localparam int P1 = 1;
  localparam int M0 = 2;
  localparam int M1 = 3;
  localparam int BL = 4;
  localparam int NUM_OBJ = 5;
  localparam int WINDOW_LEN = 17;
  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WINDOW_LEN - 1);
  localparam logic [3:0] HM_BIAS = 4'b1000;
  localparam logic [3:0] HM_OVF = 4'b0111;
  typedef enum logic [1:0] {IDLE, COUNT, REPORT} state_t;
  // A saturated counter cannot be told apart from 16 real pulses, so it reports the largest legal nibble.
  function automatic logic [3:0] hm_decode(input logic [CNT_W-1:0] cnt);
    return (cnt == CNT_MAX) ? HM_OVF : cnt[3:0] ^ HM_BIAS;
  endfunction
endpackage

// File: rtl/tia_motion_decoder_channel.sv
// tia_motion_decoder_channel: per-object saturating pulse counter with nibble decode
//   i_clk, i_rst_bar (sync, active low), i_count_en / i_clear from the window FSM,
//   i_ec_bar extra-clock strobe (active low); o_hm decoded nibble, o_ovf counter saturated.
module tia_motion_decoder_channel
  import tia_motion_decoder_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_bar,
  input  logic       i_count_en,
  input  logic       i_clear,
  input  logic       i_ec_bar,
  output logic [3:0] o_hm,
  output logic       o_ovf
);
  logic [CNT_W-1:0] r_cnt;
  always_ff @(posedge i_clk)
    if (!i_rst_bar || i_clear) r_cnt <= '0;
    else if (i_count_en && !i_ec_bar && r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
  assign o_ovf = r_cnt == CNT_MAX;
  assign o_hm = hm_decode(r_cnt);
endmodule

// File: rtl/tia_motion_decoder.sv
// tia_motion_decoder: recovers HMxx nibbles from the five extra-clock strobes of an HMOVE window
//   i_clk, i_rst_bar (sync, active low), i_sec (rise opens a window),
//   i_p0/p1/m0/m1/blec_bar extra clocks (active low);
//   o_hm_p0/p1/m0/m1/bl decoded nibbles, o_hm_valid one-cycle report strobe,
//   o_hm_ovf {bl,m1,m0,p1,p0} saturation flags, o_oow_err sticky out-of-window flag.
//   Define TIA_MOTION_DECODER_OOW_CHECK_EN to enable o_oow_err; otherwise it is tied 0.
module tia_motion_decoder
  import tia_motion_decoder_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_bar,
  input  logic       i_sec,
  input  logic       i_p0ec_bar,
  input  logic       i_p1ec_bar,
  input  logic       i_m0ec_bar,
  input  logic       i_m1ec_bar,
  input  logic       i_blec_bar,
  output logic [3:0] o_hm_p0,
  output logic [3:0] o_hm_p1,
  output logic [3:0] o_hm_m0,
  output logic [3:0] o_hm_m1,
  output logic [3:0] o_hm_bl,
  output logic       o_hm_valid,
  output logic [4:0] o_hm_ovf,
  output logic       o_oow_err
);
  state_t r_state, w_next;
  logic r_sec_q, w_rise, w_count_en, w_clear, r_hm_valid;
  logic [CNT_W-1:0] r_wcnt;
  logic [NUM_OBJ-1:0] w_ec_bar, w_ovf, r_ovf;
  logic [NUM_OBJ-1:0][3:0] w_hm, r_hm;
  assign w_ec_bar = {i_blec_bar, i_m1ec_bar, i_m0ec_bar, i_p1ec_bar, i_p0ec_bar};
  assign w_rise = i_sec & ~r_sec_q;
  always_ff @(posedge i_clk)
    if (!i_rst_bar) r_state <= IDLE;
    else r_state <= w_next;
  // The rise cycle itself is window cycle 0, so counting is enabled while still in IDLE.
  always_comb begin
    w_next = r_state;
    w_count_en = 1'b0;
    w_clear = 1'b0;
    w_next = (r_state == IDLE) ? (w_rise ? COUNT : IDLE) :
             (r_state == COUNT) ? ((r_wcnt == CNT_W'(WINDOW_LEN - 1)) ? REPORT : COUNT) : IDLE;
    w_count_en = (r_state == COUNT) || (r_state == IDLE && w_rise);
    w_clear = r_state == REPORT;
  end
  always_ff @(posedge i_clk)
    if (!i_rst_bar) begin
      r_sec_q <= 1'b0;
      r_wcnt <= '0;
      r_hm <= '0;
      r_ovf <= '0;
      r_hm_valid <= 1'b0;
    end else begin
      r_sec_q <= i_sec;
      r_wcnt <= (w_next == COUNT) ? r_wcnt + 1'b1 : '0;
      r_hm_valid <= w_clear;
      if (w_clear) begin
        r_hm <= w_hm;
        r_ovf <= w_ovf;
      end
    end
  for (genvar g = 0; g < NUM_OBJ; g++) begin : g_ch
    tia_motion_decoder_channel u_ch (
      .i_clk      (i_clk),
      .i_rst_bar  (i_rst_bar),
      .i_count_en (w_count_en),
      .i_clear    (w_clear),
      .i_ec_bar   (w_ec_bar[g]),
      .o_hm       (w_hm[g]),
      .o_ovf      (w_ovf[g])
    );
  end
`ifdef TIA_MOTION_DECODER_OOW_CHECK_EN
  logic r_oow_err;
  always_ff @(posedge i_clk)
    if (!i_rst_bar) r_oow_err <= 1'b0;
    else if (!(&w_ec_bar) && ((r_state == IDLE && !w_rise) || r_state == REPORT)) r_oow_err <= 1'b1;
  assign o_oow_err = r_oow_err;
`else
  assign o_oow_err = 1'b0;
`endif
  assign o_hm_p0 = r_hm[P0];
  assign o_hm_p1 = r_hm[P1];
  assign o_hm_m0 = r_hm[M0];
  assign o_hm_m1 = r_hm[M1];
  assign o_hm_bl = r_hm[BL];
  assign o_hm_valid = r_hm_valid;
  assign o_hm_ovf = r_ovf;
endmodule

// File: tb/tb_tia_motion_decoder.sv
// tb_tia_motion_decoder: scoreboard bench for tia_motion_decoder
module tb_tia_motion_decoder;
`ifdef TIA_MOTION_DECODER_OOW_CHECK_EN
  localparam bit OOW_EN = 1'b1;
`else
  localparam bit OOW_EN = 1'b0;
`endif
  logic clk = 1'b0, rst_bar = 1'b0, sec = 1'b0;
  logic [4:0] ec = 5'h1f;
  logic [3:0] hm_p0, hm_p1, hm_m0, hm_m1, hm_bl;
  logic hm_valid, oow_err;
  logic [4:0] hm_ovf;
  int total = 0, bad = 0, cyc = 0;
  bit exp_oow = 1'b0;
  typedef struct {logic [19:0] hm; logic [4:0] ovf; int at;} exp_t;
  exp_t q[$];
  exp_t mon_e;

  tia_motion_decoder dut (
    .i_clk(clk), .i_rst_bar(rst_bar), .i_sec(sec),
    .i_p0ec_bar(ec[0]), .i_p1ec_bar(ec[1]), .i_m0ec_bar(ec[2]),
    .i_m1ec_bar(ec[3]), .i_blec_bar(ec[4]),
    .o_hm_p0(hm_p0), .o_hm_p1(hm_p1), .o_hm_m0(hm_m0), .o_hm_m1(hm_m1), .o_hm_bl(hm_bl),
    .o_hm_valid(hm_valid), .o_hm_ovf(hm_ovf), .o_oow_err(oow_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  always @(negedge clk)
    if (rst_bar && hm_valid) begin
      chk("valid_expected", 32'(q.size() > 0), 32'd1);
      if (q.size() > 0) begin
        mon_e = q.pop_front();
        chk("hm", 32'({hm_bl, hm_m1, hm_m0, hm_p1, hm_p0}), 32'(mon_e.hm));
        chk("ovf", 32'(hm_ovf), 32'(mon_e.ovf));
        chk("latency", 32'(cyc), 32'(mon_e.at));
      end
    end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic junk_ec();
    ec = 5'($urandom);
    if (ec != 5'h1f) exp_oow = OOW_EN;
  endtask

  // Window of 17 sampled cycles starting at the sec rise; cycle 17 is the report cycle.
  // rise2 > 0: sec drops two cycles before cycle rise2 and rises again there (must be ignored).
  task automatic window(input int n[5], input int rise2);
    logic [16:0] m[5];
    exp_t e;
    int c;
    for (int o = 0; o < 5; o++) begin
      m[o] = '0;
      if (n[o] >= 17) m[o] = '1;
      else while ($countones(m[o]) < n[o]) m[o][$urandom_range(16, 0)] = 1'b1;
      c = $countones(m[o]);
      e.hm[4*o+:4] = (c >= 16) ? 4'b0111 : 4'(c - 8);
      e.ovf[o] = c >= 16;
    end
    for (int k = 0; k <= 17; k++) begin
      sec = (k == 0) || (rise2 > 0 && (k < rise2 - 2 || k >= rise2));
      if (k <= 16) for (int o = 0; o < 5; o++) ec[o] = ~m[o][k];
      else junk_ec();
      tick();
      if (k == 0) begin
        e.at = cyc + 17;
        q.push_back(e);
      end
    end
    sec = 1'b0;
    for (int i = 0; i < 2; i++) begin
      junk_ec();
      tick();
    end
    ec = 5'h1f;
  endtask

  task automatic abort_window(input int at);
    sec = 1'b1;
    for (int k = 0; k < at; k++) begin
      ec = 5'($urandom);
      tick();
      sec = 1'b0;
    end
    rst_bar = 1'b0;
    ec = 5'h1f;
    tick();
    rst_bar = 1'b1;
    exp_oow = 1'b0;
    @(negedge clk);
    chk("rst_hm", 32'({hm_bl, hm_m1, hm_m0, hm_p1, hm_p0}), 32'd0);
    chk("rst_valid", 32'(hm_valid), 32'd0);
    chk("rst_ovf", 32'(hm_ovf), 32'd0);
    chk("rst_oow", 32'(oow_err), 32'd0);
    repeat (25) tick();
  endtask

  initial begin
    int r[5];
    repeat (2) tick();
    @(negedge clk);
    chk("init_hm", 32'({hm_bl, hm_m1, hm_m0, hm_p1, hm_p0}), 32'd0);
    chk("init_valid", 32'(hm_valid), 32'd0);
    chk("init_ovf", 32'(hm_ovf), 32'd0);
    chk("init_oow", 32'(oow_err), 32'd0);
    rst_bar = 1'b1;
    tick();
    window('{15, 8, 12, 4, 10}, 0);
    window('{0, 2, 7, 11, 3}, 0);
    window('{17, 8, 8, 8, 8}, 0);
    window('{16, 1, 9, 14, 5}, 0);
    window('{6, 13, 2, 8, 15}, 5);
    window('{3, 3, 17, 0, 12}, 17);
    window('{9, 4, 1, 16, 7}, 0);
    abort_window(6);
    window('{15, 8, 12, 4, 10}, 0);
    for (int t = 0; t < 20; t++) begin
      foreach (r[i]) r[i] = $urandom_range(17, 0);
      window(r, (t % 4 == 3) ? int'($urandom_range(17, 3)) : 0);
    end
    for (int i = 0; i < 40 && q.size() > 0; i++) tick();
    chk("drain", 32'(q.size()), 32'd0);
    ec = 5'b01111;
    exp_oow = exp_oow | OOW_EN;
    tick();
    ec = 5'h1f;
    repeat (2) tick();
    @(negedge clk);
    chk("oow", 32'(oow_err), 32'(exp_oow));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
